// File: rtl/exec_stage.sv
// ---------------------------------------------------------------------------
// Module   : exec_stage
// Purpose  : Serial-operand execute stage: read A and B from the register file,
//            shift B, run the ALU, latch result/flags, then write back.
// Options  : `define EXEC_OVF_FLAG_EN to build the signed-overflow (V) flag.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module exec_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [REG_W-1:0]  rn,
  input  logic [REG_W-1:0]  rm,
  input  logic [REG_W-1:0]  rd,
  input  logic              wb_en,
  output logic [REG_W-1:0]  readnum,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [REG_W-1:0]  writenum,
  output logic              write,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              Z,
  output logic              N,
  output logic              V
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        shift_q, shift_d;
  logic [REG_W-1:0]  rn_q, rn_d;
  logic [REG_W-1:0]  rm_q, rm_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic [DATA_W-1:0] bsh;
  logic [DATA_W-1:0] alu;

  always_comb begin
    bsh = b_q;
    unique case (shift_q)
      2'b00: bsh = b_q;
      2'b01: bsh = {b_q[MSB-1:0], 1'b0};
      2'b10: bsh = {1'b0, b_q[MSB:1]};
      2'b11: bsh = {b_q[MSB], b_q[MSB:1]};
      default: bsh = b_q;
    endcase
    alu = '0;
    unique case (op_q)
      2'b00: alu = a_q + bsh;
      2'b01: alu = a_q - bsh;
      2'b10: alu = a_q & bsh;
      2'b11: alu = ~bsh;
      default: alu = '0;
    endcase
  end

`ifdef EXEC_OVF_FLAG_EN
  logic v_q, v_d;
  logic ovf;

  // Overflow exists only for ADD/SUB; logical ops clear V.
  always_comb begin
    ovf = 1'b0;
    unique case (op_q)
      2'b00: ovf = (a_q[MSB] == bsh[MSB]) && (alu[MSB] != a_q[MSB]);
      2'b01: ovf = (a_q[MSB] != bsh[MSB]) && (alu[MSB] != a_q[MSB]);
      default: ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  always_comb begin
    v_d = v_q;
    if (state_q == S_EXEC) v_d = ovf;
  end

  assign V = v_q;
`else
  assign V = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    shift_d  = shift_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    rd_d     = rd_q;
    wb_en_d  = wb_en_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    readnum  = '0;
    writenum = '0;
    wb_data  = '0;
    write    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          shift_d = shift;
          rn_d    = rn;
          rm_d    = rm;
          rd_d    = rd;
          wb_en_d = wb_en;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        readnum = rn_q;
        a_d     = rf_rdata;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        readnum = rm_q;
        b_d     = rf_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu;
        z_d      = (alu == '0);
        n_d      = alu[MSB];
        state_d  = S_WB;
      end
      S_WB: begin
        // The register file commits on the edge that leaves this state.
        done     = 1'b1;
        write    = wb_en_q;
        writenum = rd_q;
        wb_data  = result_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      shift_q  <= shift_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
      wb_en_q  <= wb_en_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign result = result_q;
  assign Z      = z_q;
  assign N      = n_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ---------------------------------------------------------------------------
// Module   : tb_exec_stage
// Purpose  : Directed test of exec_stage against a behavioural 8x16 register file.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exec_stage;

`ifdef EXEC_OVF_FLAG_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [1:0]  shift = '0;
  logic [2:0]  rn = '0, rm = '0, rd = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  readnum, writenum;
  logic [15:0] rf_rdata, wb_data, result;
  logic        write, busy, done, Z, N, V;

  logic [15:0] rf [0:7];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int checks = 0;
  int failures = 0;

  int          lat, wr_cnt;
  logic        wb_wr;
  logic [2:0]  wb_num, ra, rb;
  logic [15:0] wb_dat;

  exec_stage #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
    .rn(rn), .rm(rm), .rd(rd), .wb_en(wb_en), .readnum(readnum),
    .rf_rdata(rf_rdata), .writenum(writenum), .write(write),
    .wb_data(wb_data), .busy(busy), .done(done), .result(result),
    .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf[readnum];
  always @(posedge clk) begin
    if (write)       rf[writenum] <= wb_data;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issues one op from IDLE, records WB outputs, returns in the following IDLE cycle.
  task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic w);
    op = o; shift = s; rn = a; rm = b; rd = d; wb_en = w; start = 1'b1;
    lat = 99; wr_cnt = 0; wb_wr = 1'b0; wb_num = '0; wb_dat = '0; ra = '0; rb = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (write) wr_cnt++;
      if (i == 1) begin
        ra = readnum;
        op = ~o; shift = ~s; rn = ~a; rm = ~b; rd = ~d; wb_en = ~w;
      end
      if (i == 2) rb = readnum;
      if (done) begin
        lat = i; wb_wr = write; wb_num = writenum; wb_dat = wb_data;
        break;
      end
    end
    if (lat != 99) begin
      @(posedge clk); #1;
      if (write) wr_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0) begin failures++; $display("FAIL reset_ctrl: busy/done/write=%b%b%b expected 000", busy, done, write); end
    checks++; if (result !== 16'h0 || {Z, N, V} !== 3'b000) begin failures++; $display("FAIL reset_status: result=%h ZNV=%b%b%b expected 0000 000", result, Z, N, V); end
    checks++; if (readnum !== 3'd0 || writenum !== 3'd0 || wb_data !== 16'h0) begin failures++; $display("FAIL reset_ports: readnum=%0d writenum=%0d wb_data=%h expected 0 0 0000", readnum, writenum, wb_data); end
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0);
  endtask

  task automatic test_add;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1);
    checks++; if (lat !== 4) begin failures++; $display("FAIL add_latency: got %0d expected 4", lat); end
    checks++; if (ra !== 3'd1 || rb !== 3'd2) begin failures++; $display("FAIL add_readnum: got %0d,%0d expected 1,2", ra, rb); end
    checks++; if (wb_wr !== 1'b1 || wb_num !== 3'd3 || wb_dat !== 16'h0008) begin failures++; $display("FAIL add_wb: write=%b writenum=%0d wb_data=%h expected 1 3 0008", wb_wr, wb_num, wb_dat); end
    checks++; if (rf[3] !== 16'h0008) begin failures++; $display("FAIL add_r3: got %h expected 0008", rf[3]); end
    checks++; if ({Z, N, V} !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL add_flags: ZNV=%b%b%b busy=%b expected 000 0", Z, N, V, busy); end
  endtask

  task automatic test_sub_cmp;
    run_op(2'b01, 2'b00, 3'd2, 3'd1, 3'd4, 1'b1);
    checks++; if (rf[4] !== 16'hFFFE || result !== 16'hFFFE) begin failures++; $display("FAIL sub_neg: r4=%h result=%h expected fffe", rf[4], result); end
    checks++; if ({Z, N, V} !== 3'b010) begin failures++; $display("FAIL sub_flags: ZNV=%b%b%b expected 010", Z, N, V); end
    run_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd4, 1'b0);
    checks++; if (wr_cnt !== 0 || lat !== 4) begin failures++; $display("FAIL cmp_nowrite: writes=%0d latency=%0d expected 0 4", wr_cnt, lat); end
    checks++; if ({Z, N} !== 2'b10 || result !== 16'h0) begin failures++; $display("FAIL cmp_zero: ZN=%b%b result=%h expected 10 0000", Z, N, result); end
    checks++; if (rf[4] !== 16'hFFFE) begin failures++; $display("FAIL cmp_r4: got %h expected fffe", rf[4]); end
  endtask

  task automatic test_shift;
    preload(3'd6, 16'h8004);
    run_op(2'b11, 2'b11, 3'd0, 3'd6, 3'd7, 1'b1);
    checks++; if (rf[7] !== 16'h3FFD) begin failures++; $display("FAIL mvn_asr: r7=%h expected 3ffd", rf[7]); end
    run_op(2'b00, 2'b11, 3'd0, 3'd6, 3'd5, 1'b1);
    checks++; if (rf[5] !== 16'hC002 || N !== 1'b1) begin failures++; $display("FAIL add_asr: r5=%h N=%b expected c002 1", rf[5], N); end
    run_op(2'b00, 2'b10, 3'd0, 3'd6, 3'd5, 1'b0);
    checks++; if (result !== 16'h4002 || N !== 1'b0) begin failures++; $display("FAIL lsr1: result=%h N=%b expected 4002 0", result, N); end
    run_op(2'b00, 2'b01, 3'd0, 3'd6, 3'd5, 1'b0);
    checks++; if (result !== 16'h0008 || rf[5] !== 16'hC002) begin failures++; $display("FAIL lsl1: result=%h r5=%h expected 0008 c002", result, rf[5]); end
    run_op(2'b10, 2'b00, 3'd6, 3'd7, 3'd5, 1'b0);
    checks++; if (result !== 16'h0004 || V !== 1'b0) begin failures++; $display("FAIL and: result=%h V=%b expected 0004 0", result, V); end
  endtask

  task automatic test_overflow;
    preload(3'd4, 16'h7FFF);
    preload(3'd5, 16'h0001);
    run_op(2'b00, 2'b00, 3'd4, 3'd5, 3'd3, 1'b1);
    checks++; if (result !== 16'h8000 || N !== 1'b1 || Z !== 1'b0) begin failures++; $display("FAIL add_ovf_result: result=%h N=%b Z=%b expected 8000 1 0", result, N, Z); end
    checks++; if (V !== OVF) begin failures++; $display("FAIL add_ovf_v: V=%b expected %b", V, OVF); end
    run_op(2'b01, 2'b00, 3'd3, 3'd5, 3'd3, 1'b0);
    checks++; if (result !== 16'h7FFF || N !== 1'b0 || V !== OVF) begin failures++; $display("FAIL sub_ovf: result=%h N=%b V=%b expected 7fff 0 %b", result, N, V, OVF); end
  endtask

  task automatic test_back_to_back;
    int done_cnt, busy_cnt;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd3; wb_en = 1'b1; start = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      start = (i == 1 || i == 3);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    checks++; if (done_cnt !== 1 || busy_cnt !== 4) begin failures++; $display("FAIL ignore_start: done pulses=%0d busy cycles=%0d expected 1 4", done_cnt, busy_cnt); end
    checks++; if (rf[3] !== 16'h0008) begin failures++; $display("FAIL ignore_start_r3: got %h expected 0008", rf[3]); end
    run_op(2'b01, 2'b00, 3'd3, 3'd2, 3'd3, 1'b1);
    run_op(2'b00, 2'b00, 3'd3, 3'd3, 3'd6, 1'b1);
    checks++; if (lat !== 4 || wb_dat !== 16'h000A) begin failures++; $display("FAIL b2b: latency=%0d wb_data=%h expected 4 000a", lat, wb_dat); end
    checks++; if (rf[6] !== 16'h000A || rf[3] !== 16'h0005) begin failures++; $display("FAIL b2b_rf: r6=%h r3=%h expected 000a 0005", rf[6], rf[3]); end
  endtask

  task automatic test_reset_mid_op;
    int wr;
    preload(3'd7, 16'h1234);
    op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd7; wb_en = 1'b1; start = 1'b1;
    wr = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (write) wr++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0) begin failures++; $display("FAIL rst_exec_ctrl: busy/done/write=%b%b%b expected 000", busy, done, write); end
    checks++; if (result !== 16'h0 || {Z, N, V} !== 3'b000) begin failures++; $display("FAIL rst_exec_status: result=%h ZNV=%b%b%b expected 0000 000", result, Z, N, V); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (write || done || busy) wr++;
    end
    checks++; if (wr !== 0) begin failures++; $display("FAIL rst_exec_nowrite: activity cycles=%0d expected 0", wr); end
    checks++; if (rf[7] !== 16'h1234 || rf[1] !== 16'h0005) begin failures++; $display("FAIL rst_exec_rf: r7=%h r1=%h expected 1234 0005", rf[7], rf[1]); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub_cmp();
    test_shift();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exec_stage.md
Name: exec_stage

Overview:
Execute stage that sits directly downstream of the 8x16 register file. It drives the file's read port to fetch two operands serially, applies a shifter and ALU, and latches result and status. It then writes the result back through the file's write port. One operation at a time, with a start/done handshake to the controller.

Parameters:
DATA_W, 16, datapath width; must match the register file width
REG_W, 3, register index width (8 registers)

Ports:
clk  in  1  rising-edge clock, shared with the register file
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 MVN (~Bsh)
shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (fill 0), 11 ASR1 (fill B[15])
rn  in  REG_W  operand A register index
rm  in  REG_W  operand B register index
rd  in  REG_W  destination register index
wb_en  in  1  1 = write result to rd; 0 = flags only (compare)
readnum  out  REG_W  to register file read select
rf_rdata  in  DATA_W  from register file data_out (combinational read)
writenum  out  REG_W  to register file write select
write  out  1  to register file write enable
wb_data  out  DATA_W  to register file data_in
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in the WB state
result  out  DATA_W  latched C register
Z  out  1  zero flag
N  out  1  negative flag
V  out  1  signed-overflow flag

Behaviour:
- States: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE. Encoding is free; no other states.
- IDLE: readnum = 0, write = 0. On start=1, capture op, shift, rn, rm, rd, wb_en into internal registers and go to RD_A. Inputs are ignored after capture.
- RD_A: readnum = captured rn. At the clock edge, A <= rf_rdata.
- RD_B: readnum = captured rm. At the clock edge, B <= rf_rdata.
- EXEC: compute Bsh = shift(B), then ALU(A, Bsh) modulo 2^DATA_W.
  - At the edge: result <= ALU output, Z <= (ALU == 0), N <= ALU[DATA_W-1], V per Optional Feature.
- WB: done = 1. wb_data = result, writenum = captured rd, write = captured wb_en. The register file commits at the edge leaving WB. Next state is always IDLE.
- Latency: start sampled at edge k; done high during cycle k+4; the written value is readable from cycle k+5. Back-to-back start is accepted in the cycle after WB, and the second op sees the first op's writeback.
- start while busy=1 is ignored, with no queuing.
- readnum, writenum and wb_data hold 0 when not in their driving state. write is 0 outside WB.
- Flags and result hold their values until the next EXEC.
- rd equal to rn or rm is legal: reads complete before the write.
- Reset (any state, including mid-operation): state <= IDLE. A, B, result, Z, N, V, all captured fields <= 0. done = 0, busy = 0, write = 0 in the following cycle. An operation interrupted before WB performs no write.

Optional Feature:
EXEC_OVF_FLAG_EN
- Defined: V <= signed overflow in EXEC.
  - ADD: A and Bsh have the same sign and the result sign differs.
  - SUB: A and Bsh have different signs and the result sign differs from A.
  - AND/MVN: V <= 0.
- Undefined: V is constant 0 and no overflow logic is built.
- Z, N and result are identical in both builds.

Test Plan:
1. Preload R1=0x0005, R2=0x0003; start op=ADD shift=00 rn=1 rm=2 rd=3 wb_en=1 -> done exactly 4 cycles after start, write=1 writenum=3 wb_data=0x0008 in WB, R3 reads 0x0008, Z=0 N=0 V=0.
2. R1=0x0005, R2=0x0003; SUB rn=2 rm=1 rd=4 -> R4=0xFFFE, N=1 Z=0. Then SUB rn=1 rm=1 wb_en=0 -> Z=1, write stays 0 throughout, R4 unchanged.
3. R6=0x8004; MVN shift=11 rm=6 rd=7, then ADD rn=0(R0=0) rm=6 shift=11 rd=5 -> R7=0x3FFD, R5=0xC002 N=1. Also LSR1 of 0x8004 gives 0x4002 and LSL1 gives 0x0008.
4. R4=0x7FFF, R5=0x0001; ADD rn=4 rm=5 -> result 0x8000, N=1. V=1 with EXEC_OVF_FLAG_EN defined, V=0 without. Also SUB 0x8000-0x0001 -> 0x7FFF, V=1 (defined).
5. Pulse start again in RD_A and EXEC of a running op -> ignored, exactly one done pulse, busy stays high 4 cycles. A start the cycle after done is accepted and reads the just-written rd value.
6. Assert reset for one cycle while in EXEC -> no write pulse ever appears, next cycle busy=0 done=0 result=0 Z=N=V=0, and the register file contents are unchanged.
